// File: rtl/seq_divider_if.sv
// seq_divider_if: start/result handshake and operand/result bus for seq_divider.
interface seq_divider_if #(parameter int DVD_W = 14, parameter int DVS_W = 8);
  logic             start;
  logic [DVD_W-1:0] dividend;
  logic             dividend_sign;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             sign;
  logic             zflag;
  logic             dbz;
  modport master(output start, dividend, dividend_sign, divisor,
                 input busy, done, quotient, remainder, sign, zflag, dbz);
  modport slave(input start, dividend, dividend_sign, divisor,
                output busy, done, quotient, remainder, sign, zflag, dbz);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, sign-magnitude dividend by two's-complement divisor.
module seq_divider #(parameter int DVD_W = 14, parameter int DVS_W = 8) (
  input logic clock,
  input logic reset_n,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(DVD_W);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DVD_W-1:0] q_q, q_d, quot_q, quot_d;
  logic [DVS_W-1:0] r_q, r_d, d_q, d_d, rem_q, rem_d, dmag;
  logic [DVS_W:0]   r_sh;
  logic             ge, sp_q, sp_d, done_q, done_d, sign_q, sign_d, z_q, z_d, dbz_q, dbz_d;
  always_comb begin
    dmag    = bus.divisor[DVS_W-1] ? -bus.divisor : bus.divisor;
    r_sh    = {r_q, q_q[DVD_W-1]};
    ge      = r_sh >= {1'b0, d_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    sp_d    = sp_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    z_d     = z_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (bus.start) begin
        q_d     = bus.dividend;
        r_d     = '0;
        d_d     = dmag;
        sp_d    = bus.dividend_sign ^ bus.divisor[DVS_W-1];
        cnt_d   = '0;
        state_d = (dmag == '0) ? FIN : RUN;
      end
      RUN: begin
        // The kept remainder is always below D, so it fits back into DVS_W bits.
        r_d     = DVS_W'(ge ? r_sh - {1'b0, d_q} : r_sh);
        q_d     = {q_q[DVD_W-2:0], ge};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(DVD_W-1)) ? FIN : RUN;
      end
      default: begin
        done_d  = 1'b1;
        state_d = IDLE;
        quot_d  = (d_q == '0) ? '1 : q_q;
        rem_d   = (d_q == '0) ? '0 : r_q;
        z_d     = (d_q != '0) && (q_q == '0);
        sign_d  = (d_q != '0) && sp_q && (q_q != '0);
        dbz_d   = (d_q == '0);
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      sp_q    <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
      z_q     <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      sp_q    <= sp_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
      z_q     <= z_d;
      dbz_q   <= dbz_d;
    end
  end
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.sign      = sign_q;
  assign bus.zflag     = z_q;
  assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a result scoreboard popped on each done pulse.
module tb_seq_divider;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  seq_divider_if bus();
  seq_divider dut(.clock(clock), .reset_n(reset_n), .bus(bus));
  typedef struct packed {
    logic [13:0] q;
    logic [7:0]  r;
    logic        s;
    logic        z;
    logic        dbz;
  } res_t;
  res_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction
  res_t a, e;
  always @(negedge clock) begin
    if (reset_n && bus.done) begin
      chk("done_while_busy", 32'(bus.busy), 0);
      a = {bus.quotient, bus.remainder, bus.sign, bus.zflag, bus.dbz};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got q=%0d r=%0d with no pending vector", a.q, a.r);
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL result: got q=%0d r=%0d s=%0b z=%0b dbz=%0b expected q=%0d r=%0d s=%0b z=%0b dbz=%0b",
                   a.q, a.r, a.s, a.z, a.dbz, e.q, e.r, e.s, e.z, e.dbz);
        end
      end
    end
  end
  task automatic check_zero(string nm);
    chk({nm, "_quotient"}, 32'(bus.quotient), 0);
    chk({nm, "_remainder"}, 32'(bus.remainder), 0);
    chk({nm, "_sign"}, 32'(bus.sign), 0);
    chk({nm, "_zflag"}, 32'(bus.zflag), 0);
    chk({nm, "_dbz"}, 32'(bus.dbz), 0);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
    chk({nm, "_done"}, 32'(bus.done), 0);
  endtask
  task automatic run_op(string nm, input logic [13:0] dvd, input logic s, input logic [7:0] dvs,
                        input res_t r, input int lat, input int bsy, input int poke);
    int got, b;
    @(posedge clock); #1;
    bus.dividend = dvd;
    bus.dividend_sign = s;
    bus.divisor = dvs;
    bus.start = 1'b1;
    exp_q.push_back(r);
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.dividend = ~dvd;
    bus.divisor = ~dvs;
    got = 0;
    b = bus.busy ? 1 : 0;
    for (int i = 1; i <= 40 && got == 0; i++) begin
      bus.start = (i == poke);
      if (i == poke) begin
        bus.dividend = 14'd9;
        bus.divisor = 8'd9;
      end
      @(posedge clock); #1;
      if (bus.done) got = i;
      else if (bus.busy) b++;
    end
    bus.start = 1'b0;
    chk({nm, "_latency"}, got, lat);
    chk({nm, "_busy_cycles"}, b, bsy);
  endtask
  initial begin
    int t1, t2;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.dividend_sign = 1'b0;
    bus.divisor = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("reset_state");
    reset_n = 1'b1;
    run_op("basic_100_7", 14'd100, 1'b0, 8'd7, '{14'd14, 8'd2, 1'b0, 1'b0, 1'b0}, 15, 14, 0);
    run_op("rt_neg110", 14'd12100, 1'b1, 8'h92, '{14'd110, 8'd0, 1'b0, 1'b0, 1'b0}, 15, 14, 0);
    run_op("rt_pos110", 14'd12100, 1'b1, 8'h6E, '{14'd110, 8'd0, 1'b1, 1'b0, 1'b0}, 15, 14, 0);
    run_op("m128_small", 14'd5, 1'b1, 8'h80, '{14'd0, 8'd5, 1'b0, 1'b1, 1'b0}, 15, 14, 0);
    run_op("m128_negzero", 14'd5, 1'b0, 8'h80, '{14'd0, 8'd5, 1'b0, 1'b1, 1'b0}, 15, 14, 0);
    run_op("m128_max", 14'd16383, 1'b1, 8'h80, '{14'd127, 8'd127, 1'b0, 1'b0, 1'b0}, 15, 14, 0);
    run_op("dbz", 14'd1234, 1'b0, 8'd0, '{14'd16383, 8'd0, 1'b0, 1'b0, 1'b1}, 1, 0, 0);
    run_op("after_dbz", 14'd1000, 1'b0, 8'hFD, '{14'd333, 8'd1, 1'b1, 1'b0, 1'b0}, 15, 14, 0);
    run_op("ignored_start", 14'd200, 1'b0, 8'd3, '{14'd66, 8'd2, 1'b0, 1'b0, 1'b0}, 15, 14, 5);
    @(posedge clock); #1;
    bus.dividend = 14'd200;
    bus.dividend_sign = 1'b0;
    bus.divisor = 8'd3;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    bus.dividend = 14'd9;
    bus.divisor = 8'd9;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("busy_before_abort", 32'(bus.busy), 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_zero("abort_reset");
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    run_op("max_by_1", 14'd16383, 1'b1, 8'd1, '{14'd16383, 8'd0, 1'b1, 1'b0, 1'b0}, 15, 14, 0);
    @(posedge clock); #1;
    bus.dividend = 14'd50;
    bus.dividend_sign = 1'b0;
    bus.divisor = 8'd5;
    bus.start = 1'b1;
    exp_q.push_back('{14'd10, 8'd0, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{14'd10, 8'd1, 1'b0, 1'b0, 1'b0});
    @(posedge clock); #1;
    bus.dividend = 14'd51;
    t1 = 0;
    t2 = 0;
    for (int i = 1; i <= 60 && t2 == 0; i++) begin
      @(posedge clock); #1;
      if (bus.done) begin
        if (t1 == 0) t1 = i;
        else t2 = i;
      end
      if (t1 != 0 && i == t1 + 1) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk("b2b_first_latency", t1, 15);
    chk("b2b_gap", t2 - t1, 16);
    repeat (20) @(posedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
